// File: rtl/gear_deploy_ctrl_if.sv
// Signal bundle between the landing-gear controller and its environment.
// The controller takes the slave side; the pilot, sensors and servo take the master side.
interface gear_deploy_ctrl_if;
  logic        gear_cmd_i;
  logic        alt_valid_i;
  logic [15:0] alt_data_i;
  logic        weight_on_wheels_i;
  logic        lock_down_i;
  logic        lock_up_i;
  logic        angle_sel_o;
  logic [2:0]  gear_state_o;
  logic        fault_o;
  logic        warn_low_alt_o;

  modport master (
    output gear_cmd_i, alt_valid_i, alt_data_i, weight_on_wheels_i, lock_down_i, lock_up_i,
    input  angle_sel_o, gear_state_o, fault_o, warn_low_alt_o
  );

  modport slave (
    input  gear_cmd_i, alt_valid_i, alt_data_i, weight_on_wheels_i, lock_down_i, lock_up_i,
    output angle_sel_o, gear_state_o, fault_o, warn_low_alt_o
  );
endinterface

// File: rtl/gear_deploy_ctrl.sv
// Landing-gear deploy/retract sequencer with a debounced lever, low-altitude auto-deploy,
// travel timeout and a sticky fail-safe fault state.
module gear_deploy_ctrl #(
  parameter int          DEBOUNCE_CYCLES = 500_000,
  parameter int          TRAVEL_CYCLES   = 100_000_000,
  parameter logic [15:0] ALT_THRESH      = 16'd1000,
  parameter logic [15:0] ALT_HYST        = 16'd100
) (
  input logic               clk,
  input logic               rst,
  gear_deploy_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    UP         = 3'd0,
    DEPLOYING  = 3'd1,
    DOWN       = 3'd2,
    RETRACTING = 3'd3,
    FAULT      = 3'd4
  } gearState_e;

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TR_W = $clog2(TRAVEL_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TR_W-1:0] TRAVEL_LAST = TR_W'(TRAVEL_CYCLES - 1);
  localparam logic [16:0]     ALT_CLEAR   = {1'b0, ALT_THRESH} + {1'b0, ALT_HYST};

  logic [3:0]      syncMeta_q, syncOut_q;
  logic            cmdSync, wowSync, lockDownSync, lockUpSync;
  logic [DB_W-1:0] dbCnt_q, dbCnt_d;
  logic            cmdDb_q, cmdDb_d;
  logic            altLow_q, altLow_d;
  logic            warn_q, warn_d;
  logic [TR_W-1:0] travelCnt_q, travelCnt_d;
  gearState_e      state_q, state_d;
  logic            angleSel_q, angleSel_d;
  logic            fault_q, fault_d;
  logic            deployReq, retractOk, travelExpired;

  assign {cmdSync, wowSync, lockDownSync, lockUpSync} = syncOut_q;
  assign deployReq     = cmdDb_q | altLow_q;
  assign retractOk     = ~cmdDb_q & ~altLow_q & ~wowSync;
  assign travelExpired = (travelCnt_q == TRAVEL_LAST);

  always_comb begin
    dbCnt_d  = '0;
    cmdDb_d  = cmdDb_q;
    altLow_d = altLow_q;
    warn_d   = altLow_q & ~cmdDb_q;
    if (cmdSync != cmdDb_q) begin
      if (dbCnt_q == DB_LAST) begin
        cmdDb_d = cmdSync;
      end else begin
        dbCnt_d = dbCnt_q + DB_W'(1);
      end
    end
    // Hysteresis band: samples inside [THRESH, THRESH+HYST) leave alt_low untouched.
    if (bus.alt_valid_i) begin
      if (bus.alt_data_i < ALT_THRESH) begin
        altLow_d = 1'b1;
      end else if ({1'b0, bus.alt_data_i} >= ALT_CLEAR) begin
        altLow_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      syncMeta_q  <= '0;
      syncOut_q   <= '0;
      dbCnt_q     <= '0;
      cmdDb_q     <= 1'b1;
      altLow_q    <= 1'b0;
      warn_q      <= 1'b0;
      travelCnt_q <= '0;
      state_q     <= DEPLOYING;
      angleSel_q  <= 1'b1;
      fault_q     <= 1'b0;
    end else begin
      syncMeta_q  <= {bus.gear_cmd_i, bus.weight_on_wheels_i, bus.lock_down_i, bus.lock_up_i};
      syncOut_q   <= syncMeta_q;
      dbCnt_q     <= dbCnt_d;
      cmdDb_q     <= cmdDb_d;
      altLow_q    <= altLow_d;
      warn_q      <= warn_d;
      travelCnt_q <= travelCnt_d;
      state_q     <= state_d;
      angleSel_q  <= angleSel_d;
      fault_q     <= fault_d;
    end
  end

  // A reached lock is tested before the timeout so that a coincident lock wins.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UP: begin
        if (deployReq) state_d = DEPLOYING;
      end
      DEPLOYING: begin
        if (lockDownSync)       state_d = DOWN;
        else if (travelExpired) state_d = FAULT;
      end
      DOWN: begin
        if (!lockDownSync)  state_d = DEPLOYING;
        else if (retractOk) state_d = RETRACTING;
      end
      RETRACTING: begin
        if (lockUpSync)         state_d = UP;
        else if (deployReq)     state_d = DEPLOYING;
        else if (travelExpired) state_d = FAULT;
      end
      FAULT:   state_d = FAULT;
      default: state_d = FAULT;
    endcase
    if (lockUpSync && lockDownSync) state_d = FAULT;
  end

  // Outputs are decoded from the next state so they register alongside gear_state.
  always_comb begin
    angleSel_d = (state_d == DEPLOYING) || (state_d == DOWN) || (state_d == FAULT);
    fault_d    = (state_d == FAULT);
    if (state_d != state_q) begin
      travelCnt_d = '0;
    end else if ((state_q == DEPLOYING) || (state_q == RETRACTING)) begin
      travelCnt_d = travelCnt_q + TR_W'(1);
    end else begin
      travelCnt_d = '0;
    end
  end

  assign bus.angle_sel_o    = angleSel_q;
  assign bus.gear_state_o   = state_q;
  assign bus.fault_o        = fault_q;
  assign bus.warn_low_alt_o = warn_q;

endmodule

// File: tb/tb_gear_deploy_ctrl.sv
// Directed bench for gear_deploy_ctrl with short debounce (4) and travel (20) windows.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_gear_deploy_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  localparam logic [15:0] S_UP = 16'd0, S_DEP = 16'd1, S_DOWN = 16'd2, S_RET = 16'd3, S_FLT = 16'd4;

  gear_deploy_ctrl_if busIf();

  gear_deploy_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TRAVEL_CYCLES  (20),
    .ALT_THRESH     (16'd1000),
    .ALT_HYST       (16'd100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(busIf.slave)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic gc, input logic wow, input logic ld, input logic lu);
    busIf.gear_cmd_i         = gc;
    busIf.weight_on_wheels_i = wow;
    busIf.lock_down_i        = ld;
    busIf.lock_up_i          = lu;
  endtask

  task automatic pulseAlt(input logic [15:0] alt);
    busIf.alt_data_i  = alt;
    busIf.alt_valid_i = 1'b1;
    tick(1);
    busIf.alt_valid_i = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic checkGear(input string tag, input logic [15:0] st, input logic ang, input logic flt);
    checkOutput({tag, "_state"}, {13'd0, busIf.gear_state_o}, st);
    checkOutput({tag, "_angle"}, {15'd0, busIf.angle_sel_o}, {15'd0, ang});
    checkOutput({tag, "_fault"}, {15'd0, busIf.fault_o}, {15'd0, flt});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    busIf.alt_valid_i = 1'b0;
    busIf.alt_data_i  = 16'd0;
    tick(2);
    checkGear("reset", S_DEP, 1'b1, 1'b0);
    checkOutput("reset_warn", {15'd0, busIf.warn_low_alt_o}, 16'd0);
    rst = 1'b0;

    // Down-lock seen three edges after it is driven.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(2);
    checkGear("lockdown_2cyc", S_DEP, 1'b1, 1'b0);
    tick(1);
    checkGear("lockdown_3cyc", S_DOWN, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(6);
    checkGear("glitch", S_DOWN, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(6);
    checkGear("retract_pending", S_DOWN, 1'b1, 1'b0);
    tick(1);
    checkGear("retracting", S_RET, 1'b0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(3);
    checkGear("up", S_UP, 1'b0, 1'b0);

    pulseAlt(16'd1000);
    tick(2);
    checkGear("alt1000", S_UP, 1'b0, 1'b0);
    checkOutput("alt1000_warn", {15'd0, busIf.warn_low_alt_o}, 16'd0);

    pulseAlt(16'd900);
    tick(1);
    checkGear("alt900", S_DEP, 1'b1, 1'b0);
    checkOutput("alt900_warn", {15'd0, busIf.warn_low_alt_o}, 16'd1);
    pulseAlt(16'd1050);
    tick(1);
    checkOutput("alt1050_warn", {15'd0, busIf.warn_low_alt_o}, 16'd1);
    pulseAlt(16'd1100);
    tick(1);
    checkOutput("alt1100_warn", {15'd0, busIf.warn_low_alt_o}, 16'd0);
    checkGear("alt1100", S_DEP, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick(3);
    checkGear("wow_down", S_DOWN, 1'b1, 1'b0);
    tick(30);
    checkGear("wow_hold", S_DOWN, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(3);
    checkGear("liftoff_retract", S_RET, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick(6);
    checkGear("reverse_pending", S_RET, 1'b0, 1'b0);
    tick(1);
    checkGear("reverse", S_DEP, 1'b1, 1'b0);
    tick(19);
    checkGear("travel_19", S_DEP, 1'b1, 1'b0);
    tick(1);
    checkGear("timeout", S_FLT, 1'b1, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    tick(5);
    checkGear("fault_sticky", S_FLT, 1'b1, 1'b1);
    rst = 1'b1;
    tick(1);
    checkGear("fault_reset", S_DEP, 1'b1, 1'b0);
    rst = 1'b0;
    tick(2);
    checkGear("post_reset_2cyc", S_DEP, 1'b1, 1'b0);
    tick(1);
    checkGear("post_reset_down", S_DOWN, 1'b1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    tick(7);
    checkGear("retract2", S_RET, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    tick(3);
    checkGear("up2", S_UP, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    tick(2);
    checkGear("bothlocks_2cyc", S_UP, 1'b0, 1'b0);
    tick(1);
    checkGear("bothlocks", S_FLT, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule

// File: doc/gear_deploy_ctrl.md
GEAR_DEPLOY_CTRL -- requirements
Module: gear_deploy_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 500_000: stable cycles (10 ms at 50 MHz) required before gear_cmd is accepted.
REQ-002 Parameter TRAVEL_CYCLES, 100_000_000: maximum cycles (2 s) allowed for servo travel before a lock is seen.
REQ-003 Parameter ALT_THRESH, 16'd1000: altitude below which auto-deploy is requested.
REQ-004 Parameter ALT_HYST, 16'd100: hysteresis added to ALT_THRESH for clearing auto-deploy.
REQ-005 clk  input  1  single 50 MHz clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 gear_cmd  input  1  pilot lever, asynchronous; 1 = down, 0 = up.
REQ-008 alt_valid  input  1  one-cycle strobe qualifying alt_data.
REQ-009 alt_data  input  16  unsigned altitude sample.
REQ-010 weight_on_wheels  input  1  asynchronous; 1 = aircraft on ground.
REQ-011 lock_down / lock_up  input  1 each  asynchronous down-lock and up-lock limit switches.
REQ-012 angle_sel  output  1  servo command; 1 = deploy position, 0 = retract position.
REQ-013 gear_state  output  3  0 UP, 1 DEPLOYING, 2 DOWN, 3 RETRACTING, 4 FAULT.
REQ-014 fault  output  1  sticky fault flag.
REQ-015 warn_low_alt  output  1  auto-deploy active while the lever is up.

Function
REQ-016 gear_cmd, weight_on_wheels, lock_down and lock_up SHALL each pass through a 2-flop synchronizer before use.
REQ-017 cmd_db SHALL take the synchronized gear_cmd value only after it has differed from cmd_db for DEBOUNCE_CYCLES consecutive cycles.
- The debounce counter clears on any cycle the inputs agree.
REQ-018 alt_low SHALL set when alt_valid=1 and alt_data < ALT_THRESH.
REQ-019 alt_low SHALL clear when alt_valid=1 and alt_data >= ALT_THRESH+ALT_HYST.
- That sum is computed at 17 bits with no wrap.
- alt_low holds otherwise.
REQ-020 deploy_req = cmd_db | alt_low.
- retract_ok = ~cmd_db & ~alt_low & ~weight_on_wheels(sync).
REQ-021 FSM transitions:
- UP -> DEPLOYING on deploy_req.
- DEPLOYING -> DOWN on lock_down.
- DOWN -> RETRACTING on retract_ok.
- DOWN -> DEPLOYING if lock_down drops (re-drive).
- RETRACTING -> UP on lock_up.
- RETRACTING -> DEPLOYING on deploy_req (reversal toward down allowed).
- DEPLOYING ignores retract requests (no reversal toward up mid-travel).
REQ-022 A travel counter SHALL clear on every entry to DEPLOYING or RETRACTING and increment each cycle in those states.
- Reaching TRAVEL_CYCLES-1 without the target lock causes a transition to FAULT.
- If the lock and the timeout coincide, the lock wins.
REQ-023 Synchronized lock_up=1 and lock_down=1 together in any cycle SHALL force FAULT from any state.
REQ-024 FAULT SHALL be terminal until rst, with angle_sel=1 (fail-safe deploy) and fault=1.
REQ-025 angle_sel SHALL be 1 in DEPLOYING, DOWN and FAULT, and 0 in UP and RETRACTING.
- angle_sel is registered and changes in the same cycle as gear_state.
REQ-026 Latency: a lock edge SHALL appear on gear_state 3 cycles after the input edge (2 synchronizer cycles + 1 state register).
REQ-027 warn_low_alt SHALL equal alt_low & ~cmd_db, registered.

Reset
REQ-028 On rst=1 at a clock edge, the block SHALL load:
- gear_state=DEPLOYING, angle_sel=1, fault=0, warn_low_alt=0.
- cmd_db=1, alt_low=0.
- all synchronizers, debounce counter and travel counter set to 0.
REQ-029 Reset asserted mid-travel or in FAULT SHALL override all other activity in that cycle.
- After reset, the FSM reaches DOWN normally once lock_down is seen.

Verification (sim parameters: DEBOUNCE_CYCLES=4, TRAVEL_CYCLES=20)
REQ-030 Reset, then lock_down=1 -> gear_state goes 1->2 exactly 3 cycles later, angle_sel=1 throughout.
REQ-031 In DOWN, weight_on_wheels=0, gear_cmd=0 held 6 cycles -> RETRACTING, angle_sel=0.
- Then lock_down=0 and lock_up=1 -> UP.
- A 3-cycle gear_cmd glitch -> no change.
REQ-032 In UP, alt_valid pulse with alt_data=900 -> DEPLOYING and warn_low_alt=1.
- alt_data=1050 -> alt_low stays 1.
- alt_data=1100 -> alt_low clears.
REQ-033 In DOWN, gear_cmd=0 with weight_on_wheels=1 -> stays DOWN indefinitely.
REQ-034 In DEPLOYING with no lock for 20 cycles -> FAULT, fault=1, angle_sel=1, held until rst.
REQ-035 In UP, lock_up=1 and lock_down=1 together -> FAULT.
- In RETRACTING, gear_cmd=1 debounced -> DEPLOYING with the travel counter restarted.
